// File: rtl/deu_ib_queue.sv
// Instruction buffer between fetch and decode: a circular queue that packs up to FW
// fetched slots per cycle and presents the DW oldest entries to the decoder.
`ifndef LA64_PC_WIDTH
`define LA64_PC_WIDTH 64
`endif
`ifndef LA64_INST_WIDTH
`define LA64_INST_WIDTH 32
`endif

module deu_ib_queue #(
    parameter int DEPTH  = 8,
    parameter int FW     = 2,
    parameter int DW     = 2,
    parameter int PC_W   = `LA64_PC_WIDTH,
    parameter int INST_W = `LA64_INST_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [FW-1:0]              ifu_valid,
    input  logic [FW*PC_W-1:0]         ifu_pc,
    input  logic [FW*INST_W-1:0]       ifu_inst,
    output logic                       ib_ready,
    input  logic                       deu_flush,
    input  logic [DW-1:0]              deu_decode,
    output logic [DW-1:0]              deu_val,
    output logic [DW*PC_W-1:0]         deu_pc,
    output logic [DW*INST_W-1:0]       deu_inst,
    output logic [$clog2(DEPTH+1)-1:0] ib_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [AW-1:0]     head;
    logic [AW-1:0]     tail;
    logic [CW-1:0]     cnt;
    logic [PC_W-1:0]   pc_mem   [DEPTH];
    logic [INST_W-1:0] inst_mem [DEPTH];
    logic [CW-1:0]     wr_off   [FW];
    logic [CW-1:0]     wr_n;
    logic [CW-1:0]     rd_n;
    logic              accept;

    assign ib_cnt   = cnt;
    assign ib_ready = (cnt <= CW'(DEPTH - FW));
    assign accept   = ib_ready && (|ifu_valid) && !deu_flush;

    // Each valid slot lands at tail plus the number of valid slots below it, closing holes.
    always_comb begin
        wr_n = '0;
        for (int k = 0; k < FW; k++) begin
            wr_off[k] = wr_n;
            if (ifu_valid[k]) wr_n = wr_n + CW'(1);
        end
    end

    always_comb begin
        deu_val  = '0;
        deu_pc   = '0;
        deu_inst = '0;
        for (int j = 0; j < DW; j++) begin
            deu_val[j]                    = (j < int'(cnt));
            deu_pc[j*PC_W +: PC_W]        = pc_mem[head + AW'(j)];
            deu_inst[j*INST_W +: INST_W]  = inst_mem[head + AW'(j)];
        end
    end

    // Only a contiguous run of requests from slot 0 is honoured.
    always_comb begin
        logic run;
        run  = 1'b1;
        rd_n = '0;
        for (int j = 0; j < DW; j++) begin
            if (run && deu_decode[j] && deu_val[j]) rd_n = rd_n + CW'(1);
            else                                    run  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else if (deu_flush) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            head <= head + AW'(rd_n);
            if (accept) tail <= tail + AW'(wr_n);
            cnt  <= cnt + (accept ? wr_n : CW'(0)) - rd_n;
        end
    end

    // Storage carries no reset; an entry is meaningful only while counted by cnt.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int k = 0; k < FW; k++) begin
                if (ifu_valid[k]) begin
                    pc_mem[tail + AW'(wr_off[k])]   <= ifu_pc[k*PC_W +: PC_W];
                    inst_mem[tail + AW'(wr_off[k])] <= ifu_inst[k*INST_W +: INST_W];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && !deu_flush) begin
            assert (int'(cnt) + (accept ? int'(wr_n) : 0) - int'(rd_n) <= DEPTH);
        end
    end

endmodule

// File: tb/tb_deu_ib_queue.sv
// Bench for deu_ib_queue: directed stimulus with a scoreboard queue of expected entries
// checked every cycle by an independent monitor, plus hand-computed spot checks.
module tb_deu_ib_queue;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  ifu_valid = '0;
    logic [63:0] ifu_pc = '0;
    logic [63:0] ifu_inst = '0;
    logic        ib_ready;
    logic        deu_flush = 1'b0;
    logic [1:0]  deu_decode = '0;
    logic [1:0]  deu_val;
    logic [63:0] deu_pc;
    logic [63:0] deu_inst;
    logic [3:0]  ib_cnt;

    logic [3:0]   v4 = '0;
    logic [127:0] pc4 = '0;
    logic [127:0] inst4 = '0;
    logic         rdy4;
    logic [1:0]   dec4 = '0;
    logic         flush4 = 1'b0;
    logic [1:0]   val4;
    logic [63:0]  dpc4;
    logic [63:0]  dinst4;
    logic [3:0]   cnt4;

    int   checks = 0;
    int   errors = 0;
    int   seq = 0;
    ent_t exp_q[$];
    logic [31:0] pc_b;

    always #5 clk = ~clk;

    deu_ib_queue #(.DEPTH(8), .FW(2), .DW(2), .PC_W(32), .INST_W(32)) u_dut (
        .clk(clk), .rst_n(rst_n), .ifu_valid(ifu_valid), .ifu_pc(ifu_pc),
        .ifu_inst(ifu_inst), .ib_ready(ib_ready), .deu_flush(deu_flush),
        .deu_decode(deu_decode), .deu_val(deu_val), .deu_pc(deu_pc),
        .deu_inst(deu_inst), .ib_cnt(ib_cnt)
    );

    deu_ib_queue #(.DEPTH(8), .FW(4), .DW(2), .PC_W(32), .INST_W(32)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .ifu_valid(v4), .ifu_pc(pc4),
        .ifu_inst(inst4), .ib_ready(rdy4), .deu_flush(flush4),
        .deu_decode(dec4), .deu_val(val4), .deu_pc(dpc4),
        .deu_inst(dinst4), .ib_cnt(cnt4)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic [1:0] v, input logic [1:0] d, input logic f);
        @(posedge clk);
        #1;
        ifu_valid  = v;
        deu_decode = d;
        deu_flush  = f;
        for (int k = 0; k < 2; k++) begin
            ifu_pc[k*32 +: 32]   = 32'(32'h1000 + seq * 4);
            ifu_inst[k*32 +: 32] = 32'(32'hA500_0000 + seq);
            seq++;
        end
    endtask

    always @(negedge rst_n) exp_q.delete();

    // Monitor: compare visible state against the scoreboard, then apply this cycle's inputs.
    always @(negedge clk) begin
        if (rst_n) begin
            int   sz;
            int   n;
            logic run;
            logic rdy_m;
            logic [1:0] ev;
            sz    = exp_q.size();
            rdy_m = (8 - sz >= 2);
            chk("mon_cnt", 64'(ib_cnt), 64'(sz));
            chk("mon_ready", 64'(ib_ready), 64'(rdy_m));
            for (int j = 0; j < 2; j++) ev[j] = (j < sz);
            chk("mon_val", 64'(deu_val), 64'(ev));
            for (int j = 0; j < 2; j++) begin
                if (j < sz) begin
                    chk("mon_pc", 64'(deu_pc[j*32 +: 32]), 64'(exp_q[j].pc));
                    chk("mon_inst", 64'(deu_inst[j*32 +: 32]), 64'(exp_q[j].inst));
                end
            end
            n   = 0;
            run = 1'b1;
            for (int j = 0; j < 2; j++) begin
                if (run && deu_decode[j] && j < sz) n++;
                else run = 1'b0;
            end
            if (deu_flush) begin
                exp_q.delete();
            end else begin
                repeat (n) void'(exp_q.pop_front());
                if (rdy_m && |ifu_valid) begin
                    for (int k = 0; k < 2; k++)
                        if (ifu_valid[k]) exp_q.push_back({ifu_pc[k*32 +: 32], ifu_inst[k*32 +: 32]});
                end
            end
        end
    end

    initial begin
        #3;
        chk("rst_cnt", 64'(ib_cnt), 64'd0);
        chk("rst_ready", 64'(ib_ready), 64'd1);
        chk("rst_val", 64'(deu_val), 64'd0);
        #9 rst_n = 1'b1;

        // Holes on the four-wide instance: slots 1 and 3 only.
        step(2'b00, 2'b00, 1'b0);
        v4  = 4'b1010;
        pc4 = {32'hDDDD, 32'hCCCC, 32'hBBBB, 32'hAAAA};
        step(2'b00, 2'b00, 1'b0);
        v4  = 4'b0000;
        chk("holes_cnt", 64'(cnt4), 64'd2);
        chk("holes_val", 64'(val4), 64'd3);
        chk("holes_pc0", 64'(dpc4[31:0]), 64'h0000_BBBB);
        chk("holes_pc1", 64'(dpc4[63:32]), 64'h0000_DDDD);

        // Fill to full, then one dropped group.
        step(2'b11, 2'b00, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            step(2'b11, 2'b00, 1'b0);
            chk("fill_cnt", 64'(ib_cnt), 64'(2 * i));
        end
        step(2'b00, 2'b00, 1'b0);
        chk("full_cnt", 64'(ib_cnt), 64'd8);
        chk("full_ready", 64'(ib_ready), 64'd0);

        repeat (4) step(2'b00, 2'b11, 1'b0);
        step(2'b00, 2'b00, 1'b0);
        chk("drain_cnt", 64'(ib_cnt), 64'd0);

        // Non-prefix decode consumes nothing.
        step(2'b11, 2'b00, 1'b0);
        step(2'b01, 2'b00, 1'b0);
        step(2'b00, 2'b10, 1'b0);
        step(2'b00, 2'b00, 1'b0);
        chk("nonprefix_cnt", 64'(ib_cnt), 64'd3);
        step(2'b00, 2'b01, 1'b0);
        step(2'b00, 2'b00, 1'b0);
        chk("prefix1_cnt", 64'(ib_cnt), 64'd2);

        // Steady write 2 / decode 2 across several pointer wraps.
        for (int i = 0; i < 20; i++) begin
            step(2'b11, 2'b11, 1'b0);
            chk("wrap_cnt", 64'(ib_cnt), 64'd2);
        end
        step(2'b00, 2'b00, 1'b0);
        chk("wrap_end_cnt", 64'(ib_cnt), 64'd2);

        // Write and decode together while empty.
        step(2'b00, 2'b11, 1'b0);
        step(2'b11, 2'b11, 1'b0);
        step(2'b00, 2'b00, 1'b0);
        chk("empty_wd_cnt", 64'(ib_cnt), 64'd2);

        // Write and decode together while full (write dropped), then at 6.
        repeat (3) step(2'b11, 2'b00, 1'b0);
        step(2'b11, 2'b11, 1'b0);
        step(2'b00, 2'b00, 1'b0);
        chk("full_wd_cnt", 64'(ib_cnt), 64'd6);
        step(2'b11, 2'b11, 1'b0);
        step(2'b00, 2'b00, 1'b0);
        chk("six_wd_cnt", 64'(ib_cnt), 64'd6);

        // Flush overrides same-cycle write and decode.
        step(2'b11, 2'b11, 1'b1);
        step(2'b00, 2'b00, 1'b0);
        chk("flush_cnt", 64'(ib_cnt), 64'd0);
        chk("flush_val", 64'(deu_val), 64'd0);
        chk("flush_ready", 64'(ib_ready), 64'd1);

        // Asynchronous reset pulse between edges with data held.
        step(2'b11, 2'b00, 1'b0);
        step(2'b11, 2'b00, 1'b0);
        pc_b = ifu_pc[31:0];
        #1 rst_n = 1'b0;
        #1;
        chk("arst_cnt", 64'(ib_cnt), 64'd0);
        chk("arst_val", 64'(deu_val), 64'd0);
        chk("arst_ready", 64'(ib_ready), 64'd1);
        #1 rst_n = 1'b1;
        step(2'b00, 2'b00, 1'b0);
        chk("post_rst_cnt", 64'(ib_cnt), 64'd2);
        chk("post_rst_pc0", 64'(deu_pc[31:0]), 64'(pc_b));

        step(2'b00, 2'b00, 1'b0);
        step(2'b00, 2'b00, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/deu_ib_queue.md
DEU_IB_QUEUE -- requirements
Module: deu_ib_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8: entry count; power of 2, DEPTH >= 2*FW.
REQ-002 SHALL have parameter FW, default 2: fetch slots per cycle, range 1..4.
REQ-003 SHALL have parameter DW, default 2: decode slots per cycle, range 1..DEPTH.
REQ-004 SHALL have parameter PC_W, default `LA64_PC_WIDTH: PC width.
REQ-005 SHALL have parameter INST_W, default `LA64_INST_WIDTH: instruction width.
REQ-006 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-007 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-008 SHALL have port ifu_valid, input, FW: per-slot fetch valid.
REQ-009 SHALL have port ifu_pc, input, FW*PC_W: per-slot PC, slot k at bits [k*PC_W +: PC_W].
REQ-010 SHALL have port ifu_inst, input, FW*INST_W: per-slot instruction, packed the same way.
REQ-011 SHALL have port ib_ready, output, 1: the queue accepts a fetch group this cycle.
REQ-012 SHALL have port deu_flush, input, 1: discard all contents.
REQ-013 SHALL have port deu_decode, input, DW: per-slot consume request.
REQ-014 SHALL have port deu_val, output, DW: slot j holds the j-th oldest entry.
REQ-015 SHALL have port deu_pc, output, DW*PC_W: PC of the j-th oldest entry.
REQ-016 SHALL have port deu_inst, output, DW*INST_W: instruction of the j-th oldest entry.
REQ-017 SHALL have port ib_cnt, output, $clog2(DEPTH+1): number of occupied entries.

Function
REQ-018 SHALL be a circular FIFO with head and tail pointers of $clog2(DEPTH) bits that wrap modulo DEPTH.
REQ-019 SHALL drive ib_ready = (DEPTH - ib_cnt >= FW) from registered state only, with no combinational path from deu_decode or deu_flush.
REQ-020 SHALL accept a fetch group when ib_ready=1 and at least one ifu_valid bit is set; when ib_ready=0 the group is dropped and the IFU holds it.
REQ-021 SHALL pack accepted valid slots in ascending slot order into consecutive entries starting at tail, skipping holes (ifu_valid=4'b1010 with FW=4 writes slot1 then slot3).
REQ-022 SHALL advance tail by popcount(ifu_valid) on acceptance.
REQ-023 SHALL set deu_val[j] = (j < ib_cnt) and drive deu_pc/deu_inst[j] from entry (head+j) mod DEPTH; when deu_val[j]=0, deu_pc/deu_inst[j] are don't-care.
REQ-024 SHALL consume n entries, where n = the number of leading ones of deu_decode starting at bit 0, masked by deu_val; bits above the first zero are ignored.
REQ-025 SHALL advance head by n and update ib_cnt = ib_cnt + written - n in the same edge.
REQ-026 SHALL make a written entry visible on deu_* one cycle after acceptance; there is no same-cycle bypass.
REQ-027 SHALL support simultaneous write and consume with no loss, including when the queue is full or empty at the start of the cycle.
REQ-028 SHALL, on deu_flush=1, set head=tail=0 and ib_cnt=0 at the next edge; flush overrides any same-cycle write and decode.
REQ-029 SHALL drive ib_ready=1 and deu_val all zero in the cycle after a flush.
REQ-030 SHALL leave entry storage unreset, with validity derived solely from ib_cnt.
REQ-031 SHALL keep ib_cnt within 0..DEPTH under all legal stimulus; an implementation assertion flags overflow.

Reset
REQ-032 SHALL, while rst_n=0, asynchronously force head=0, tail=0, ib_cnt=0, deu_val=0 and ib_ready=1.
REQ-033 SHALL discard any in-flight write or decode when rst_n is asserted mid-operation, and SHALL start from the empty state at the first edge after deassertion.

Verification
REQ-034 SHALL cover fill (defaults): ifu_valid=2'b11 each cycle with no decode -> ib_cnt 2,4,6,8; ib_ready=0 at cnt=8; further groups dropped.
REQ-035 SHALL cover holes: FW=4, ifu_valid=4'b1010, PCs A,B,C,D -> next cycle deu_pc[0]=B, deu_pc[1]=D, ib_cnt=2.
REQ-036 SHALL cover wrap-around: 20 cycles of write 2 / decode 2 -> output order matches write order across pointer wrap; ib_cnt constant.
REQ-037 SHALL cover non-prefix decode: ib_cnt=3 and deu_decode=2'b10 -> nothing consumed, ib_cnt stays 3.
REQ-038 SHALL cover flush: ib_cnt=6 with flush, write and decode all asserted in one cycle -> next cycle ib_cnt=0, deu_val=0, ib_ready=1.
REQ-039 SHALL cover async reset mid-stream: rst_n pulsed low between edges -> outputs cleared immediately; first post-reset write appears at deu_*[0].
